icache_miss_responder: RTL and testbench

//  Memory-side end of the icache miss path: accepts miss2mem requests (block addr, instr id) from the icache MSHR,

---
 rtl/icache_miss_responder.sv | 191 +++++++++++++++++++
 tb/tb_icache_miss_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_responder.sv
// Memory-side end of the icache miss path: allocates a source slot per miss, issues it on the
// A channel, assembles the multi-beat D refill and returns one full-line response to the icache.
module icache_miss_responder #(
    parameter int BA_BITS       = 7,
    parameter int WID_BITS      = 2,
    parameter int NUM_SRC       = 4,
    parameter int SRC_BITS      = 2,
    parameter int BEAT_BITS     = 32,
    parameter int NUM_BEATS     = 4,
    parameter int BEAT_CNT_BITS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_req_valid_i,
    output logic                           miss_req_ready_o,
    input  logic [BA_BITS-1:0]             miss_req_block_addr_i,
    input  logic [WID_BITS-1:0]            miss_req_instr_id_i,
    output logic                           mem_a_valid_o,
    input  logic                           mem_a_ready_i,
    output logic [BA_BITS-1:0]             mem_a_addr_o,
    output logic [SRC_BITS-1:0]            mem_a_source_o,
    input  logic                           mem_d_valid_i,
    output logic                           mem_d_ready_o,
    input  logic [SRC_BITS-1:0]            mem_d_source_i,
    input  logic [BEAT_BITS-1:0]           mem_d_data_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [BA_BITS-1:0]             rsp_block_addr_o,
    output logic [WID_BITS-1:0]            rsp_instr_id_o,
    output logic [NUM_BEATS*BEAT_BITS-1:0] rsp_data_o,
    output logic                           err_o
);

    localparam logic [BEAT_CNT_BITS-1:0] LAST_BEAT = BEAT_CNT_BITS'(NUM_BEATS - 1);

    typedef enum logic [0:0] {
        ST_RECV = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                           state_r;
    state_t                           state_nxt_s;
    logic [NUM_SRC-1:0]               slot_valid_r;
    logic [BA_BITS-1:0]               slot_addr_r [NUM_SRC];
    logic [WID_BITS-1:0]              slot_id_r   [NUM_SRC];
    logic [BEAT_CNT_BITS-1:0]         cnt_r;
    logic [SRC_BITS-1:0]              cur_src_r;
    logic [NUM_BEATS*BEAT_BITS-1:0]   buf_r;
    logic                             d_ready_r;
    logic                             rsp_valid_r;
    logic [BA_BITS-1:0]               rsp_addr_r;
    logic [WID_BITS-1:0]              rsp_id_r;
    logic                             err_r;

    logic                             any_free_s;
    logic [SRC_BITS-1:0]              free_idx_s;
    logic                             req_fire_s;
    logic                             d_fire_s;
    logic                             drop_s;
    logic                             mism_s;
    logic                             store_s;
    logic                             last_s;
    logic                             rsp_fire_s;
    logic [SRC_BITS-1:0]              src_sel_s;

    // Lowest-index free slot, scanned from the top so the smallest index wins
    always_comb begin
        any_free_s = 1'b0;
        free_idx_s = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!slot_valid_r[i]) begin
                any_free_s = 1'b1;
                free_idx_s = i[SRC_BITS-1:0];
            end else begin
                any_free_s = any_free_s;
            end
        end
    end

    assign mem_a_valid_o    = miss_req_valid_i & any_free_s;
    assign miss_req_ready_o = mem_a_ready_i & any_free_s;
    assign mem_a_addr_o     = miss_req_block_addr_i;
    assign mem_a_source_o   = free_idx_s;
    assign req_fire_s       = miss_req_valid_i & miss_req_ready_o;

    // Beat qualification: a line may only start on a live slot; later beats always land
    always_comb begin
        d_fire_s   = mem_d_valid_i & d_ready_r;
        src_sel_s  = (cnt_r == '0) ? mem_d_source_i : cur_src_r;
        drop_s     = d_fire_s & (cnt_r == '0) & ~slot_valid_r[mem_d_source_i];
        mism_s     = d_fire_s & (cnt_r != '0) & (mem_d_source_i != cur_src_r);
        store_s    = d_fire_s & ~drop_s;
        last_s     = store_s & (cnt_r == LAST_BEAT);
        rsp_fire_s = rsp_valid_r & rsp_ready_i;
    end

    // Refill FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RECV: begin
                if (last_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_SEND: begin
                if (rsp_fire_s) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: state_nxt_s = ST_RECV;
        endcase
    end

    // Slot table: allocate on request fire, release on response fire (never the same slot)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_addr_r[i] <= '0;
                slot_id_r[i]   <= '0;
            end
        end else begin
            if (req_fire_s) begin
                slot_valid_r[free_idx_s] <= 1'b1;
                slot_addr_r[free_idx_s]  <= miss_req_block_addr_i;
                slot_id_r[free_idx_s]    <= miss_req_instr_id_i;
            end
            if (rsp_fire_s) begin
                slot_valid_r[cur_src_r] <= 1'b0;
            end
        end
    end

    // FSM state, beat counter, current source and line buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RECV;
            d_ready_r <= 1'b0;
            cnt_r     <= '0;
            cur_src_r <= '0;
            buf_r     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            d_ready_r <= (state_nxt_s == ST_RECV);
            if (store_s) begin
                buf_r[int'(cnt_r)*BEAT_BITS +: BEAT_BITS] <= mem_d_data_i;
                cnt_r <= cnt_r + 1'b1;
                if (cnt_r == '0) begin
                    cur_src_r <= mem_d_source_i;
                end
            end
        end
    end

    // Response header registers, captured as the final beat lands and held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_addr_r  <= '0;
            rsp_id_r    <= '0;
        end else if (last_s) begin
            rsp_valid_r <= 1'b1;
            rsp_addr_r  <= slot_addr_r[src_sel_s];
            rsp_id_r    <= slot_id_r[src_sel_s];
        end else if (rsp_fire_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    // Protocol-error pulse for dropped or mismatched beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= drop_s | mism_s;
        end
    end

    assign mem_d_ready_o    = d_ready_r;
    assign rsp_valid_o      = rsp_valid_r;
    assign rsp_block_addr_o = rsp_addr_r;
    assign rsp_instr_id_o   = rsp_id_r;
    assign rsp_data_o       = buf_r;
    assign err_o            = err_r;

endmodule

// File: tb/tb_icache_miss_responder.sv
// Directed bench for icache_miss_responder: allocation table plus hand-written refill,
// back-pressure, error and mid-line reset sequences.
module tb_icache_miss_responder;

    logic         clk;
    logic         rst_n;
    logic         miss_req_valid_i;
    logic         miss_req_ready_o;
    logic [6:0]   miss_req_block_addr_i;
    logic [1:0]   miss_req_instr_id_i;
    logic         mem_a_valid_o;
    logic         mem_a_ready_i;
    logic [6:0]   mem_a_addr_o;
    logic [1:0]   mem_a_source_o;
    logic         mem_d_valid_i;
    logic         mem_d_ready_o;
    logic [1:0]   mem_d_source_i;
    logic [31:0]  mem_d_data_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [6:0]   rsp_block_addr_o;
    logic [1:0]   rsp_instr_id_o;
    logic [127:0] rsp_data_o;
    logic         err_o;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       req_valid;
        logic       a_ready;
        logic [6:0] addr;
        logic [1:0] id;
        logic       exp_a_valid;
        logic       exp_req_ready;
        logic [1:0] exp_src;
    } req_vec_t;

    req_vec_t vt [5];

    icache_miss_responder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .miss_req_valid_i      (miss_req_valid_i),
        .miss_req_ready_o      (miss_req_ready_o),
        .miss_req_block_addr_i (miss_req_block_addr_i),
        .miss_req_instr_id_i   (miss_req_instr_id_i),
        .mem_a_valid_o         (mem_a_valid_o),
        .mem_a_ready_i         (mem_a_ready_i),
        .mem_a_addr_o          (mem_a_addr_o),
        .mem_a_source_o        (mem_a_source_o),
        .mem_d_valid_i         (mem_d_valid_i),
        .mem_d_ready_o         (mem_d_ready_o),
        .mem_d_source_i        (mem_d_source_i),
        .mem_d_data_i          (mem_d_data_i),
        .rsp_valid_o           (rsp_valid_o),
        .rsp_ready_i           (rsp_ready_i),
        .rsp_block_addr_o      (rsp_block_addr_o),
        .rsp_instr_id_o        (rsp_instr_id_o),
        .rsp_data_o            (rsp_data_o),
        .err_o                 (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [6:0] addr, input logic [1:0] id, input logic [1:0] exp_src);
        miss_req_valid_i      = 1'b1;
        mem_a_ready_i         = 1'b1;
        miss_req_block_addr_i = addr;
        miss_req_instr_id_i   = id;
        #1;
        chk("req_ready", 128'(miss_req_ready_o), 128'(1'b1));
        chk("a_source", 128'(mem_a_source_o), 128'(exp_src));
        chk("a_addr", 128'(mem_a_addr_o), 128'(addr));
        cyc();
        miss_req_valid_i = 1'b0;
        mem_a_ready_i    = 1'b0;
    endtask

    task automatic beat(input logic [1:0] src, input logic [31:0] data);
        int n;
        n              = 0;
        mem_d_valid_i  = 1'b1;
        mem_d_source_i = src;
        mem_d_data_i   = data;
        #1;
        while (!mem_d_ready_o && n < 10) begin
            cyc();
            n++;
        end
        if (!mem_d_ready_o) begin
            chk("d_ready_timeout", 128'(mem_d_ready_o), 128'(1'b1));
        end
        cyc();
        mem_d_valid_i = 1'b0;
    endtask

    task automatic line(input logic [1:0] src, input logic [31:0] base);
        for (int b = 0; b < 4; b++) begin
            beat(src, base + 32'(b));
        end
    endtask

    task automatic take_rsp();
        rsp_ready_i = 1'b1;
        cyc();
        rsp_ready_i = 1'b0;
        chk("rsp_dropped", 128'(rsp_valid_o), 128'(1'b0));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_a_valid"}, 128'(mem_a_valid_o), 128'(1'b0));
        chk({tag, "_req_ready"}, 128'(miss_req_ready_o), 128'(1'b0));
        chk({tag, "_d_ready"}, 128'(mem_d_ready_o), 128'(1'b0));
        chk({tag, "_rsp_valid"}, 128'(rsp_valid_o), 128'(1'b0));
        chk({tag, "_rsp_addr"}, 128'(rsp_block_addr_o), 128'(7'h00));
        chk({tag, "_rsp_data"}, rsp_data_o, 128'h0);
        chk({tag, "_err"}, 128'(err_o), 128'(1'b0));
    endtask

    initial begin
        tests_run             = 0;
        tests_failed          = 0;
        rst_n                 = 1'b0;
        miss_req_valid_i      = 1'b0;
        mem_a_ready_i         = 1'b0;
        miss_req_block_addr_i = 7'h00;
        miss_req_instr_id_i   = 2'd0;
        mem_d_valid_i         = 1'b0;
        mem_d_source_i        = 2'd0;
        mem_d_data_i          = 32'h0;
        rsp_ready_i           = 1'b0;

        vt[0] = '{1'b1, 1'b1, 7'h01, 2'd0, 1'b1, 1'b1, 2'd0};
        vt[1] = '{1'b1, 1'b1, 7'h02, 2'd1, 1'b1, 1'b1, 2'd1};
        vt[2] = '{1'b1, 1'b1, 7'h03, 2'd2, 1'b1, 1'b1, 2'd2};
        vt[3] = '{1'b1, 1'b1, 7'h04, 2'd3, 1'b1, 1'b1, 2'd3};
        vt[4] = '{1'b1, 1'b1, 7'h05, 2'd0, 1'b0, 1'b0, 2'd0};

        // Reset state
        #1;
        chk_idle_outputs("reset");
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_d_ready", 128'(mem_d_ready_o), 128'(1'b1));

        // Single miss, four beats, one-cycle response latency
        do_req(7'h12, 2'd1, 2'd0);
        beat(2'd0, 32'hA);
        beat(2'd0, 32'hB);
        beat(2'd0, 32'hC);
        beat(2'd0, 32'hD);
        chk("t1_rsp_valid", 128'(rsp_valid_o), 128'(1'b1));
        chk("t1_rsp_addr", 128'(rsp_block_addr_o), 128'(7'h12));
        chk("t1_rsp_id", 128'(rsp_instr_id_o), 128'(2'd1));
        chk("t1_rsp_data", rsp_data_o, 128'h0000000D_0000000C_0000000B_0000000A);
        chk("t1_err", 128'(err_o), 128'(1'b0));
        take_rsp();

        // Allocation table: four slots fill in order, fifth request blocked
        for (int i = 0; i < 5; i++) begin
            miss_req_valid_i      = vt[i].req_valid;
            mem_a_ready_i         = vt[i].a_ready;
            miss_req_block_addr_i = vt[i].addr;
            miss_req_instr_id_i   = vt[i].id;
            #1;
            chk($sformatf("vec%0d_a_valid", i), 128'(mem_a_valid_o), 128'(vt[i].exp_a_valid));
            chk($sformatf("vec%0d_req_ready", i), 128'(miss_req_ready_o), 128'(vt[i].exp_req_ready));
            if (vt[i].exp_a_valid) begin
                chk($sformatf("vec%0d_source", i), 128'(mem_a_source_o), 128'(vt[i].exp_src));
            end
            cyc();
        end
        miss_req_valid_i = 1'b0;
        mem_a_ready_i    = 1'b0;

        // Refill src2 with response back-pressured for 5 cycles
        line(2'd2, 32'h20);
        mem_d_valid_i  = 1'b1;
        mem_d_source_i = 2'd1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_rsp_valid", 128'(rsp_valid_o), 128'(1'b1));
            chk("stall_rsp_addr", 128'(rsp_block_addr_o), 128'(7'h03));
            chk("stall_rsp_id", 128'(rsp_instr_id_o), 128'(2'd2));
            chk("stall_rsp_data", rsp_data_o, 128'h00000023_00000022_00000021_00000020);
            chk("stall_d_ready", 128'(mem_d_ready_o), 128'(1'b0));
            cyc();
        end
        mem_d_valid_i = 1'b0;
        take_rsp();

        // Fifth request now takes the freed slot 2
        do_req(7'h05, 2'd0, 2'd2);

        // Response of src1 fires in the same cycle as a request into a full table
        line(2'd1, 32'h60);
        chk("t4_rsp_addr", 128'(rsp_block_addr_o), 128'(7'h02));
        rsp_ready_i           = 1'b1;
        miss_req_valid_i      = 1'b1;
        mem_a_ready_i         = 1'b1;
        miss_req_block_addr_i = 7'h06;
        miss_req_instr_id_i   = 2'd3;
        #1;
        chk("same_cycle_req_ready", 128'(miss_req_ready_o), 128'(1'b0));
        chk("same_cycle_a_valid", 128'(mem_a_valid_o), 128'(1'b0));
        cyc();
        rsp_ready_i = 1'b0;
        chk("next_cycle_req_ready", 128'(miss_req_ready_o), 128'(1'b1));
        chk("next_cycle_source", 128'(mem_a_source_o), 128'(2'd1));
        cyc();
        miss_req_valid_i = 1'b0;
        mem_a_ready_i    = 1'b0;

        // Drain src3, then a stray beat on the now-empty slot 3
        line(2'd3, 32'h70);
        chk("t5_rsp_addr", 128'(rsp_block_addr_o), 128'(7'h04));
        take_rsp();
        beat(2'd3, 32'hDEAD);
        chk("stray_err", 128'(err_o), 128'(1'b1));
        chk("stray_no_rsp", 128'(rsp_valid_o), 128'(1'b0));
        cyc();
        chk("stray_err_pulse", 128'(err_o), 128'(1'b0));

        // Mid-line source mismatch: pulse, but the line is still returned
        beat(2'd0, 32'h30);
        chk("mism_first_err", 128'(err_o), 128'(1'b0));
        beat(2'd1, 32'h31);
        chk("mism_err", 128'(err_o), 128'(1'b1));
        beat(2'd0, 32'h32);
        chk("mism_err_pulse", 128'(err_o), 128'(1'b0));
        beat(2'd0, 32'h33);
        chk("mism_rsp_valid", 128'(rsp_valid_o), 128'(1'b1));
        chk("mism_rsp_addr", 128'(rsp_block_addr_o), 128'(7'h01));
        chk("mism_rsp_data", rsp_data_o, 128'h00000033_00000032_00000031_00000030);
        take_rsp();

        // Reset after two beats of src1
        beat(2'd1, 32'h40);
        beat(2'd1, 32'h41);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        cyc();
        rst_n = 1'b1;
        mem_a_ready_i = 1'b1;
        #1;
        chk("release_req_ready_hi", 128'(miss_req_ready_o), 128'(1'b1));
        mem_a_ready_i = 1'b0;
        #1;
        chk("release_req_ready_lo", 128'(miss_req_ready_o), 128'(1'b0));
        cyc();
        beat(2'd1, 32'h42);
        chk("stale_beat_err", 128'(err_o), 128'(1'b1));
        do_req(7'h33, 2'd2, 2'd0);
        line(2'd0, 32'h50);
        chk("clean_rsp_addr", 128'(rsp_block_addr_o), 128'(7'h33));
        chk("clean_rsp_id", 128'(rsp_instr_id_o), 128'(2'd2));
        chk("clean_rsp_data", rsp_data_o, 128'h00000053_00000052_00000051_00000050);
        chk("clean_err", 128'(err_o), 128'(1'b0));
        take_rsp();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
